// File: rtl/jk_bank_sequencer.sv
// Round-robin sequencer sharing a bank of JK flip-flops between NREQ requesters.
// Each command drives one bit's j/k for a single cycle, then checks q against the expected value.
module jk_bank_sequencer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op_in,
    input  logic [SELW*NREQ-1:0] sel_in,
    input  logic [WIDTH-1:0]     q,
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     j,
    output logic [WIDTH-1:0]     k,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t            state_reg;
    logic [PW-1:0]     rr_ptr_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic [WIDTH-1:0]  j_reg;
    logic [WIDTH-1:0]  k_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [WIDTH-1:0]  sel_dec_reg;
    logic              exp_reg;
    logic              range_err_reg;

    // Round-robin pick: lowest requester at or above rr_ptr, else wrap to the lowest overall.
    logic [NREQ-1:0]   ptr_mask;
    logic [NREQ-1:0]   req_hi;
    logic [NREQ-1:0]   pick_src;
    logic [NREQ-1:0]   win_onehot;

    assign ptr_mask   = {NREQ{1'b1}} << rr_ptr_reg;
    assign req_hi     = req & ptr_mask;
    assign pick_src   = (|req_hi) ? req_hi : req;
    assign win_onehot = pick_src & (~pick_src + NREQ'(1));

    logic [NREQ:0][1:0]      op_acc;
    logic [NREQ:0][SELW-1:0] sel_acc;
    logic [NREQ:0][PW-1:0]   idx_acc;

    assign op_acc[0]  = '0;
    assign sel_acc[0] = '0;
    assign idx_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
            assign op_acc[gi+1]  = op_acc[gi]  | (op_in[2*gi +: 2] & {2{win_onehot[gi]}});
            assign sel_acc[gi+1] = sel_acc[gi] | (sel_in[SELW*gi +: SELW] & {SELW{win_onehot[gi]}});
            assign idx_acc[gi+1] = idx_acc[gi] | (PW'(gi) & {PW{win_onehot[gi]}});
        end
    endgenerate

    logic [1:0]        win_op;
    logic [SELW-1:0]   win_sel;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     ptr_next;

    assign win_op   = op_acc[NREQ];
    assign win_sel  = sel_acc[NREQ];
    assign win_idx  = idx_acc[NREQ];
    assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

    // One-hot bit decode; an out-of-range sel decodes to all zeros.
    logic [WIDTH-1:0]  sel_dec;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign sel_dec[gi] = (win_sel == SELW'(gi));
        end
    endgenerate

    logic win_qbit;
    logic in_range;
    logic exp_next;
    logic readback;

    assign win_qbit = |(q & sel_dec);
    assign in_range = |sel_dec;
    assign readback = |(q & sel_dec_reg);

    always_comb begin
        exp_next = 1'b0;
        case (win_op)
            2'b00:   exp_next = win_qbit;
            2'b01:   exp_next = 1'b0;
            2'b10:   exp_next = 1'b1;
            default: exp_next = ~win_qbit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            gnt_reg       <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            sel_dec_reg   <= '0;
            exp_reg       <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    if (|req) begin
                        gnt_reg       <= win_onehot;
                        j_reg         <= sel_dec & {WIDTH{win_op[1]}};
                        k_reg         <= sel_dec & {WIDTH{win_op[0]}};
                        sel_dec_reg   <= sel_dec;
                        exp_reg       <= exp_next;
                        range_err_reg <= ~in_range;
                        rr_ptr_reg    <= ptr_next;
                        busy_reg      <= 1'b1;
                        state_reg     <= DRIVE;
                    end
                end
                DRIVE: begin
                    gnt_reg   <= '0;
                    j_reg     <= '0;
                    k_reg     <= '0;
                    state_reg <= CHECK;
                end
                CHECK: begin
                    done_reg  <= 1'b1;
                    err_reg   <= range_err_reg | (readback != exp_reg);
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_reg;
    assign j    = j_reg;
    assign k    = k_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule
